// File: rtl/lorenz_dac_streamer.sv
// lorenz_dac_streamer: converts the Lorenz X/Y/Z states to 12-bit offset-binary codes and streams them as SPI frames to DAC channels 0-2; define LORENZ_DAC_LDAC_EN for a simultaneous LDAC update
module lorenz_dac_streamer #(
  parameter int SHIFT   = 15,
  parameter int CLK_DIV = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [26:0] X_K,
  input  logic [26:0] Y_K,
  input  logic [26:0] Z_K,
  input  logic        overrun_clr,
  output logic        busy,
  output logic        overrun,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_cs_n
`ifdef LORENZ_DAC_LDAC_EN
  ,
  output logic        dac_ldac_n
`endif
);
  localparam int PER = 2 * CLK_DIV;
  localparam int CW = $clog2(PER);
  localparam logic [CW-1:0] LAST = CW'(PER - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
`ifdef LORENZ_DAC_LDAC_EN
  localparam logic [1:0] CMD = 2'b00;
`else
  localparam logic [1:0] CMD = 2'b01;
`endif
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_LDAC} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] ch_q, ch_d;
  logic [15:0] frame_q, frame_d;
  logic [2:0][11:0] code_q, code_d;
  logic overrun_q, overrun_d;
  logic sclk_q, mosi_q, cs_n_q;
  logic last, done, accept;
  logic [11:0] next_code;

  function automatic logic [11:0] to_code(input logic [26:0] s);
    logic signed [26:0] t;
    t = $signed(s) >>> SHIFT;
    return (t > 27'sd2047) ? 12'hFFF : (t < -27'sd2048) ? 12'h000 : {~t[11], t[10:0]};
  endfunction

  assign busy = state_q != S_IDLE;
  assign last = cnt_q == LAST;
`ifdef LORENZ_DAC_LDAC_EN
  assign done = state_q == S_LDAC && last;
`else
  assign done = state_q == S_GAP && last && ch_q == 2'd2;
`endif
  assign accept = sample_valid && (!busy || done);
  assign overrun_d = (sample_valid && !accept) || (overrun_q && !overrun_clr);
  assign next_code = ch_q == 2'd0 ? code_q[1] : code_q[2];
  assign overrun = overrun_q;
  assign dac_sclk = sclk_q;
  assign dac_mosi = mosi_q;
  assign dac_cs_n = cs_n_q;

  // sequencer: capture, per-channel frame load, 16-bit shift with divided bit timing, inter-frame gap
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    ch_d = ch_q;
    frame_d = frame_q;
    code_d = code_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_LOAD: begin
        frame_d = {CMD, 2'd0, code_q[0]};
        ch_d = 2'd0;
        bit_d = 4'd0;
        cnt_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          frame_d = {frame_q[14:0], 1'b0};
          bit_d = bit_q + 4'd1;
          state_d = bit_q == 4'd15 ? S_GAP : S_SHIFT;
        end
      end
      S_GAP: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last && ch_q != 2'd2) begin
          ch_d = ch_q + 2'd1;
          frame_d = {CMD, ch_q + 2'd1, next_code};
          bit_d = 4'd0;
          state_d = S_SHIFT;
        end else if (last) begin
`ifdef LORENZ_DAC_LDAC_EN
          state_d = S_LDAC;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_LDAC: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        state_d = last ? S_IDLE : S_LDAC;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      code_d = {to_code(Z_K), to_code(Y_K), to_code(X_K)};
      state_d = S_LOAD;
    end
  end

  // sequencer and captured-code registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= 4'd0;
      ch_q <= 2'd0;
      frame_q <= 16'd0;
      code_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      ch_q <= ch_d;
      frame_q <= frame_d;
      code_q <= code_d;
      overrun_q <= overrun_d;
    end
  end

  // SPI pins are registered from the sequencer so MOSI only moves on the SCLK falling edge
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      sclk_q <= state_q == S_SHIFT && cnt_q >= HALF;
      mosi_q <= state_q == S_SHIFT && frame_q[15];
      cs_n_q <= state_q != S_SHIFT;
    end
  end

`ifdef LORENZ_DAC_LDAC_EN
  logic ldac_n_q;
  assign dac_ldac_n = ldac_n_q;

  // LDAC pulse after the last gap updates all three channels together
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) ldac_n_q <= 1'b1;
    else ldac_n_q <= state_q != S_LDAC;
  end
`endif
endmodule

// File: tb/tb_lorenz_dac_streamer.sv
// tb_lorenz_dac_streamer: scoreboard bench driving two streamers (SHIFT 15 and 10) from shared stimulus
module tb_lorenz_dac_streamer;
  localparam int CD = 2;
  localparam int P = 2 * CD;
`ifdef LORENZ_DAC_LDAC_EN
  localparam int CMD = 0;
  localparam int BUSY = 1 + 104 * CD;
`else
  localparam int CMD = 1;
  localparam int BUSY = 1 + 102 * CD;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_valid = 1'b0;
  logic overrun_clr = 1'b0;
  logic [26:0] xk = '0, yk = '0, zk = '0;
  logic busy [2], overrun [2], sclk [2], mosi [2], cs_n [2];
`ifdef LORENZ_DAC_LDAC_EN
  logic ldac_n [2];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lorenz_dac_streamer #(.SHIFT(g == 0 ? 15 : 10), .CLK_DIV(CD)) u_dut (
      .CLOCK_50(clk),
      .reset(rst),
      .sample_valid(sample_valid),
      .X_K(xk),
      .Y_K(yk),
      .Z_K(zk),
      .overrun_clr(overrun_clr),
      .busy(busy[g]),
      .overrun(overrun[g]),
      .dac_sclk(sclk[g]),
      .dac_mosi(mosi[g]),
      .dac_cs_n(cs_n[g])
`ifdef LORENZ_DAC_LDAC_EN
      ,
      .dac_ldac_n(ldac_n[g])
`endif
    );
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [26:0] v);
    return v[26] ? int'(v) - 134217728 : int'(v);
  endfunction

  function automatic int code_of(input int s, input int sh);
    int d, t;
    d = 1 << sh;
    t = s >= 0 ? s / d : -((-s + d - 1) / d);
    if (t > 2047) t = 2047;
    if (t < -2048) t = -2048;
    return t + 2048;
  endfunction

  function automatic logic [15:0] frame_of(input int ch, input int code);
    return 16'(CMD * 16384 + ch * 4096 + code);
  endfunction

  function automatic logic [2:0] wave(input int d);
    logic [2:0] w;
    int r;
    w = '0;
    if (d >= 0 && d < 102 * CD) begin
      r = d % (34 * CD);
      w[2] = r < 32 * CD;
      w[1] = r < 32 * CD && (r % P) >= CD;
    end
`ifdef LORENZ_DAC_LDAC_EN
    if (d >= 102 * CD && d < 104 * CD) w[0] = 1'b1;
`endif
    return w;
  endfunction

  // reference model: acceptance window, overrun flag and expected frames
  int cyc = 0, last_edge = -1, free_at = 0, e_cur = 0, e_prev = 0;
  bit have_cur = 0, have_prev = 0, ov_m = 0;
  logic [1:0][15:0] exp_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have_cur = 0;
      have_prev = 0;
      free_at = 0;
      ov_m = 0;
      exp_q.delete();
    end else begin
      bit set;
      int s;
      set = 0;
      if (sample_valid) begin
        if (cyc >= free_at) begin
          e_prev = e_cur;
          have_prev = have_cur;
          e_cur = cyc;
          have_cur = 1;
          free_at = cyc + BUSY;
          for (int k = 0; k < 3; k++) begin
            s = k == 0 ? sx(xk) : k == 1 ? sx(yk) : sx(zk);
            exp_q.push_back({frame_of(k, code_of(s, 10)), frame_of(k, code_of(s, 15))});
          end
        end else set = 1;
      end
      ov_m = set || (ov_m && !overrun_clr);
      last_edge = cyc;
      cyc++;
    end
  end

  // monitor: per-cycle pin checks and SPI frame decode against the scoreboard
  logic [15:0] sh [2];
  int nb [2];
  logic prev_sk [2], prev_cs [2];
  logic [15:0] rx0 [$], rx1 [$];
  logic [1:0][15:0] cur;
  bit cur_ok;

  always @(negedge clk) begin
    logic [2:0] w;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        nb[d] = 0;
        sh[d] = '0;
        prev_sk[d] = 1'b0;
        prev_cs[d] = 1'b1;
      end
    end else begin
      w = (have_cur ? wave(last_edge - e_cur - 2) : 3'b0) | (have_prev ? wave(last_edge - e_prev - 2) : 3'b0);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy%0d", d), 32'(busy[d]), 32'(have_cur && last_edge < free_at));
        check($sformatf("overrun%0d", d), 32'(overrun[d]), 32'(ov_m));
        check($sformatf("cs_n%0d", d), 32'(cs_n[d]), 32'(!w[2]));
        check($sformatf("sclk%0d", d), 32'(sclk[d]), 32'(w[1]));
        if (cs_n[d]) check($sformatf("mosi_idle%0d", d), 32'(mosi[d]), 0);
`ifdef LORENZ_DAC_LDAC_EN
        check($sformatf("ldac_n%0d", d), 32'(ldac_n[d]), 32'(!w[0]));
`endif
        if (!cs_n[d] && sclk[d] && !prev_sk[d]) begin
          sh[d] = {sh[d][14:0], mosi[d]};
          nb[d]++;
        end
        if (cs_n[d] && !prev_cs[d]) begin
          check($sformatf("edges%0d", d), nb[d], 16);
          if (d == 0) begin
            cur_ok = exp_q.size() > 0;
            if (cur_ok) cur = exp_q.pop_front();
            else check("unexpected_frame", 32'(sh[0]), 32'hFFFF_FFFF);
            rx0.push_back(sh[0]);
          end else rx1.push_back(sh[1]);
          if (cur_ok) check($sformatf("frame%0d", d), 32'(sh[d]), 32'(cur[d]));
          nb[d] = 0;
        end
        prev_sk[d] = sclk[d];
        prev_cs[d] = cs_n[d];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [26:0] x, input logic [26:0] y, input logic [26:0] z, input bit clr);
    @(negedge clk);
    sample_valid = 1'b1;
    xk = x;
    yk = y;
    zk = z;
    overrun_clr = clr;
    @(negedge clk);
    sample_valid = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy[0] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) check("idle_timeout", n, 0);
  endtask

  task automatic clear_ov();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, n0;
    idle(3);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_overrun", 32'(overrun[0]), 0);
    check("rst_sclk", 32'(sclk[0]), 0);
    check("rst_mosi", 32'(mosi[0]), 0);
    check("rst_cs_n", 32'(cs_n[0]), 1);
`ifdef LORENZ_DAC_LDAC_EN
    check("rst_ldac_n", 32'(ldac_n[0]), 1);
`endif
    rst = 1'b0;
    idle(3);

    n0 = rx0.size();
    pulse(27'h7F00000, 27'h001999A, 27'h1900000, 0);
    wait_idle(n);
`ifdef LORENZ_DAC_LDAC_EN
    check("busy_len", n, 209);
`else
    check("busy_len", n, 205);
`endif
    idle(6);
    if (rx0.size() < n0 + 3 || rx1.size() < n0 + 3) check("frame_count", rx0.size(), n0 + 3);
    else begin
`ifdef LORENZ_DAC_LDAC_EN
      check("word_x", 32'(rx0[n0]), 32'h07E0);
      check("word_y", 32'(rx0[n0 + 1]), 32'h1803);
      check("word_z", 32'(rx0[n0 + 2]), 32'h2B20);
      check("sat_hi", 32'(rx1[n0 + 2]), 32'h2FFF);
`else
      check("word_x", 32'(rx0[n0]), 32'h47E0);
      check("word_y", 32'(rx0[n0 + 1]), 32'h5803);
      check("word_z", 32'(rx0[n0 + 2]), 32'h6B20);
      check("sat_hi", 32'(rx1[n0 + 2]), 32'h6FFF);
`endif
    end

    n0 = rx1.size();
    pulse(27'h0, 27'h0, 27'h6700000, 0);
    wait_idle(n);
    idle(6);
    if (rx1.size() < n0 + 3) check("frame_count_lo", rx1.size(), n0 + 3);
`ifdef LORENZ_DAC_LDAC_EN
    else check("sat_lo", 32'(rx1[n0 + 2]), 32'h2000);
`else
    else check("sat_lo", 32'(rx1[n0 + 2]), 32'h6000);
`endif

    pulse(27'h0123456, 27'h7E54321, 27'h0ABCDEF, 0);
    idle(48);
    pulse(27'h1111111, 27'h2222222, 27'h3333333, 0);
    check("overrun_set", 32'(overrun[0]), 1);
    idle(20);
    pulse(27'h0444444, 27'h0555555, 27'h0666666, 1);
    check("overrun_set_wins", 32'(overrun[0]), 1);
    idle(5);
    clear_ov();
    check("overrun_clr", 32'(overrun[0]), 0);
    wait_idle(n);
    idle(4);

    pulse(27'h0200000, 27'h7C00000, 27'h0080000, 0);
    idle(80);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_cs_n", 32'(cs_n[0]), 1);
    check("midrst_sclk", 32'(sclk[0]), 0);
    check("midrst_mosi", 32'(mosi[0]), 0);
    check("midrst_busy", 32'(busy[0]), 0);
    idle(2);
    rst = 1'b0;
    idle(3);
    n0 = rx0.size();
    pulse(27'h0300000, 27'h0010000, 27'h7000000, 0);
    wait_idle(n);
    idle(6);
    if (rx0.size() < n0 + 1) check("frame_count_rst", rx0.size(), n0 + 1);
    else check("first_ch_after_rst", 32'(rx0[n0][13:12]), 0);

    pulse(27'h0FFFFFF, 27'h7000001, 27'h0000100, 0);
    repeat (BUSY - 2) @(negedge clk);
    pulse(27'h0765432, 27'h0012345, 27'h7ABCDEF, 0);
    check("coincident_no_overrun", 32'(overrun[0]), 0);
    check("coincident_busy", 32'(busy[0]), 1);
    wait_idle(n);
    idle(6);

    for (int i = 0; i < 10; i++) begin
      logic [26:0] x, y, z;
      x = 27'($urandom);
      y = 27'(int'($urandom_range(0, 4194304)) - 2097152);
      z = 27'(($urandom_range(0, 1) == 1 ? 1 : -1) * (2096128 + int'($urandom_range(0, 2047))));
      pulse(x, y, z, $urandom_range(0, 3) == 0);
      idle(int'($urandom_range(20, 240)));
    end
    wait_idle(n);
    idle(10);
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
